writeback_unit: RTL and testbench

//  Write-back stage and write-port producer for the decode-stage register file.

---
 rtl/writeback_unit.sv | 188 ++++++++++++++++++
 tb/tb_writeback_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Write-back stage: retires one instruction per handshake from execute and
// produces the register-file write port (data, index, one-cycle strobe).
module writeback_unit #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [1:0]  ex_kind_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [31:0] ex_result_i,
    input  logic [31:0] ex_pc_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [1:0]  ex_addr_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] wd_o,
    output logic        wd_q_o,
    output logic [4:0]  wd_rd_o,
    output logic        retire_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    // state    | meaning
    // IDLE     | ready for the next retiring instruction
    // WAIT_MEM | load accepted, waiting for mem_valid_i or timeout
    // WRITE    | single cycle with the write strobe (unless rd==0)
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        WRITE    = 2'b10
    } state_t;

    localparam logic [1:0]      KIND_ALU  = 2'b01;
    localparam logic [1:0]      KIND_LOAD = 2'b10;
    localparam logic [1:0]      KIND_LINK = 2'b11;
    localparam logic [TO_W-1:0] CNT_LAST  = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      addr_q, addr_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [31:0]     wd_d;
    logic [4:0]      wd_rd_d;
    logic            wd_q_d, retire_d, misalign_d, timeout_d;
    logic            accept, ex_misaligned, mem_last;
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [31:0]     load_data;

    assign ex_ready_o = (state_q == IDLE) & reset;
    assign accept     = ex_valid_i & ex_ready_o;
    assign mem_last   = (cnt_q == CNT_LAST);

    // funct3[1] set means word access (011/110/111 fold into LW)
    always_comb begin
        if (ex_funct3_i[1])
            ex_misaligned = (ex_addr_i != 2'b00);
        else if (ex_funct3_i[0])
            ex_misaligned = ex_addr_i[0];
        else
            ex_misaligned = 1'b0;
    end

    always_comb begin
        byte_lane = mem_rdata_i[{addr_q, 3'b000} +: 8];
        half_lane = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        if (f3_q[1])
            load_data = mem_rdata_i;
        else if (f3_q[0])
            load_data = f3_q[2] ? {16'h0000, half_lane} : {{16{half_lane[15]}}, half_lane};
        else
            load_data = f3_q[2] ? {24'h000000, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ex_kind_i == KIND_ALU || ex_kind_i == KIND_LINK)
                        state_d = WRITE;
                    else if (ex_kind_i == KIND_LOAD && !ex_misaligned)
                        state_d = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (mem_valid_i)
                    state_d = WRITE;
                else if (mem_last)
                    state_d = IDLE;
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs; pulses default low, data holds.
    always_comb begin
        wd_d       = wd_o;
        wd_rd_d    = wd_rd_o;
        wd_q_d     = 1'b0;
        retire_d   = 1'b0;
        misalign_d = 1'b0;
        timeout_d  = 1'b0;
        rd_d       = rd_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (ex_kind_i)
                        KIND_ALU, KIND_LINK: begin
                            wd_d     = (ex_kind_i == KIND_ALU) ? ex_result_i : ex_pc_i + 32'd4;
                            wd_rd_d  = ex_rd_i;
                            wd_q_d   = (ex_rd_i != 5'd0);
                            retire_d = 1'b1;
                        end
                        KIND_LOAD: begin
                            if (ex_misaligned) begin
                                misalign_d = 1'b1;
                                retire_d   = 1'b1;
                            end else begin
                                rd_d   = ex_rd_i;
                                f3_d   = ex_funct3_i;
                                addr_d = ex_addr_i;
                                cnt_d  = '0;
                            end
                        end
                        default: retire_d = 1'b1;
                    endcase
                end
            end
            WAIT_MEM: begin
                if (mem_valid_i) begin
                    wd_d     = load_data;
                    wd_rd_d  = rd_q;
                    wd_q_d   = (rd_q != 5'd0);
                    retire_d = 1'b1;
                end else if (mem_last) begin
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_o       <= '0;
            wd_rd_o    <= '0;
            wd_q_o     <= 1'b0;
            retire_o   <= 1'b0;
            misalign_o <= 1'b0;
            timeout_o  <= 1'b0;
            rd_q       <= '0;
            f3_q       <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            wd_o       <= wd_d;
            wd_rd_o    <= wd_rd_d;
            wd_q_o     <= wd_q_d;
            retire_o   <= retire_d;
            misalign_o <= misalign_d;
            timeout_o  <= timeout_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus randomized instruction
// streams checked against a behavioural load/extend model.
`timescale 1ns/1ps
module tb_writeback_unit;

    localparam logic [1:0] K_NONE = 2'b00, K_ALU = 2'b01, K_LOAD = 2'b10, K_LINK = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [1:0]  ex_kind_i = '0;
    logic [4:0]  ex_rd_i = '0;
    logic [31:0] ex_result_i = '0;
    logic [31:0] ex_pc_i = '0;
    logic [2:0]  ex_funct3_i = '0;
    logic [1:0]  ex_addr_i = '0;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] wd_o;
    logic        wd_q_o;
    logic [4:0]  wd_rd_o;
    logic        retire_o, misalign_o, timeout_o;

    int total = 0;
    int bad   = 0;

    logic [36:0] wr_q[$];
    int retire_cnt = 0, misalign_cnt = 0, timeout_cnt = 0, run = 0, run_max = 0;

    writeback_unit #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .reset(reset),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_kind_i(ex_kind_i), .ex_rd_i(ex_rd_i), .ex_result_i(ex_result_i),
        .ex_pc_i(ex_pc_i), .ex_funct3_i(ex_funct3_i), .ex_addr_i(ex_addr_i),
        .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
        .wd_o(wd_o), .wd_q_o(wd_q_o), .wd_rd_o(wd_rd_o),
        .retire_o(retire_o), .misalign_o(misalign_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Records the register-file view: each strobed write and every pulse.
    always @(negedge clk) begin
        if (reset) begin
            if (wd_q_o) begin
                wr_q.push_back({wd_rd_o, wd_o});
                run = run + 1;
                if (run > run_max) run_max = run;
            end else begin
                run = 0;
            end
            retire_cnt   = retire_cnt + int'(retire_o);
            misalign_cnt = misalign_cnt + int'(misalign_o);
            timeout_cnt  = timeout_cnt + int'(timeout_o);
        end
    end

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'd0: begin v = (w >> (8 * int'(a))) & 32'hFF;           if (v >= 32'd128)   v = v - 32'd256;   end
            3'd1: begin v = (w >> (16 * (int'(a) / 2))) & 32'hFFFF;  if (v >= 32'd32768) v = v - 32'd65536; end
            3'd4: v = (w >> (8 * int'(a))) & 32'hFF;
            3'd5: v = (w >> (16 * (int'(a) / 2))) & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return (int'(a) % 2) != 0;
        return a != 2'd0;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Presents one instruction; returns at the negedge one cycle after acceptance.
    task automatic issue(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] res,
                         input logic [31:0] pc, input logic [2:0] f3, input logic [1:0] a);
        int k;
        k = 0;
        while (!ex_ready_o && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!ex_ready_o) begin
            total++; bad++;
            $display("FAIL issue_ready: ex_ready_o=%0b required 1", ex_ready_o);
        end
        ex_valid_i = 1'b1; ex_kind_i = kind; ex_rd_i = rd; ex_result_i = res;
        ex_pc_i = pc; ex_funct3_i = f3; ex_addr_i = a;
        @(posedge clk);
        #1 ex_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic mem_respond(input logic [31:0] w);
        mem_valid_i = 1'b1; mem_rdata_i = w;
        @(posedge clk);
        #1 mem_valid_i = 1'b0; mem_rdata_i = $urandom;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        total++;
        if ({wd_o, wd_q_o, wd_rd_o, retire_o, misalign_o, timeout_o, ex_ready_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: wd=%h q=%b rd=%0d ret=%b mis=%b to=%b rdy=%b required all 0",
                     wd_o, wd_q_o, wd_rd_o, retire_o, misalign_o, timeout_o, ex_ready_o);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (ex_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: ex_ready_o=%b required 1", ex_ready_o); end
    endtask

    task automatic test_alu();
        issue(K_ALU, 5'd5, 32'hDEADBEEF, 32'h0, 3'd0, 2'd0);
        total++;
        if ({wd_q_o, wd_o, wd_rd_o, ex_ready_o, retire_o} !== {1'b1, 32'hDEADBEEF, 5'd5, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL alu_write: q=%b wd=%h rd=%0d rdy=%b ret=%b required 1 deadbeef 5 0 1",
                     wd_q_o, wd_o, wd_rd_o, ex_ready_o, retire_o);
        end
        @(negedge clk);
        total++;
        if ({wd_q_o, ex_ready_o, wd_o} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL alu_after: q=%b rdy=%b wd=%h required 0 1 deadbeef", wd_q_o, ex_ready_o, wd_o);
        end
    endtask

    task automatic test_load_examples();
        issue(K_LOAD, 5'd6, 32'h0, 32'h0, 3'd0, 2'd2);
        total++;
        if (ex_ready_o !== 1'b0) begin bad++; $display("FAIL load_wait_ready: ex_ready_o=%b required 0", ex_ready_o); end
        mem_respond(32'h1280_3456);
        total++;
        if ({wd_q_o, wd_o, wd_rd_o} !== {1'b1, 32'hFFFFFF80, 5'd6}) begin
            bad++;
            $display("FAIL load_lb: q=%b wd=%h rd=%0d required 1 ffffff80 6", wd_q_o, wd_o, wd_rd_o);
        end
        issue(K_LOAD, 5'd7, 32'h0, 32'h0, 3'd5, 2'd2);
        mem_respond(32'h1280_3456);
        total++;
        if ({wd_q_o, wd_o, wd_rd_o} !== {1'b1, 32'h00001280, 5'd7}) begin
            bad++;
            $display("FAIL load_lhu: q=%b wd=%h rd=%0d required 1 00001280 7", wd_q_o, wd_o, wd_rd_o);
        end
    endtask

    task automatic test_misalign();
        issue(K_LOAD, 5'd4, 32'h0, 32'h0, 3'd2, 2'd1);
        total++;
        if ({misalign_o, retire_o, wd_q_o, ex_ready_o} !== 4'b1101) begin
            bad++;
            $display("FAIL misalign_lw: mis=%b ret=%b q=%b rdy=%b required 1 1 0 1", misalign_o, retire_o, wd_q_o, ex_ready_o);
        end
        @(negedge clk);
        total++;
        if ({misalign_o, retire_o} !== 2'b00) begin
            bad++;
            $display("FAIL misalign_pulse: mis=%b ret=%b required 0 0", misalign_o, retire_o);
        end
        issue(K_LOAD, 5'd4, 32'h0, 32'h0, 3'd1, 2'd3);
        total++;
        if ({misalign_o, wd_q_o} !== 2'b10) begin
            bad++;
            $display("FAIL misalign_lh: mis=%b q=%b required 1 0", misalign_o, wd_q_o);
        end
    endtask

    task automatic test_link();
        issue(K_LINK, 5'd1, 32'h0, 32'hFFFFFFFC, 3'd0, 2'd0);
        total++;
        if ({wd_q_o, wd_o, wd_rd_o} !== {1'b1, 32'h00000000, 5'd1}) begin
            bad++;
            $display("FAIL link_wrap: q=%b wd=%h rd=%0d required 1 00000000 1", wd_q_o, wd_o, wd_rd_o);
        end
        issue(K_LINK, 5'd31, 32'h0, 32'h0000_1000, 3'd0, 2'd0);
        total++;
        if ({wd_q_o, wd_o, wd_rd_o} !== {1'b1, 32'h00001004, 5'd31}) begin
            bad++;
            $display("FAIL link_plain: q=%b wd=%h rd=%0d required 1 00001004 31", wd_q_o, wd_o, wd_rd_o);
        end
    endtask

    task automatic test_timeout();
        int wbase;
        settle(1);
        wbase = wr_q.size();
        issue(K_LOAD, 5'd9, 32'h0, 32'h0, 3'd2, 2'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if ({timeout_o, ex_ready_o} !== {(k == 4), (k == 4)}) begin
                bad++;
                $display("FAIL timeout_cycle%0d: to=%b rdy=%b required %0d %0d", k, timeout_o, ex_ready_o, k == 4, k == 4);
            end
        end
        total++;
        if ({retire_o, wd_q_o} !== 2'b00) begin
            bad++;
            $display("FAIL timeout_nowrite: ret=%b q=%b required 0 0", retire_o, wd_q_o);
        end
        settle(2);
        total++;
        if (wr_q.size() != wbase) begin
            bad++;
            $display("FAIL timeout_writes: writes=%0d required %0d", wr_q.size(), wbase);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b;
        b = $urandom;
        settle(1);
        ex_valid_i = 1'b1; ex_kind_i = K_ALU; ex_rd_i = 5'd0; ex_result_i = $urandom;
        @(posedge clk);
        #1 ex_rd_i = 5'd3; ex_result_i = b;
        @(negedge clk);
        total++;
        if ({wd_q_o, retire_o, ex_ready_o} !== 3'b010) begin
            bad++;
            $display("FAIL b2b_rd0: q=%b ret=%b rdy=%b required 0 1 0", wd_q_o, retire_o, ex_ready_o);
        end
        @(negedge clk);
        total++;
        if ({wd_q_o, retire_o, ex_ready_o} !== 3'b001) begin
            bad++;
            $display("FAIL b2b_gap: q=%b ret=%b rdy=%b required 0 0 1", wd_q_o, retire_o, ex_ready_o);
        end
        @(posedge clk);
        #1 ex_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({wd_q_o, wd_rd_o, wd_o} !== {1'b1, 5'd3, b}) begin
            bad++;
            $display("FAIL b2b_rd3: q=%b rd=%0d wd=%h required 1 3 %h", wd_q_o, wd_rd_o, wd_o, b);
        end
        @(negedge clk);
        total++;
        if (wd_q_o !== 1'b0) begin bad++; $display("FAIL b2b_end: q=%b required 0", wd_q_o); end
    endtask

    task automatic test_reset_mid();
        int wbase, rbase;
        settle(1);
        wbase = wr_q.size();
        rbase = retire_cnt;
        issue(K_LOAD, 5'd7, 32'h0, 32'h0, 3'd2, 2'd0);
        #1 reset = 1'b0;
        #1;
        total++;
        if ({wd_o, wd_q_o, wd_rd_o, retire_o, misalign_o, timeout_o, ex_ready_o} !== '0) begin
            bad++;
            $display("FAIL reset_wait_outputs: wd=%h q=%b rd=%0d rdy=%b required all 0", wd_o, wd_q_o, wd_rd_o, ex_ready_o);
        end
        @(negedge clk);
        reset = 1'b1;
        mem_respond($urandom);
        total++;
        if ({wd_q_o, retire_o, ex_ready_o, wd_o} !== {3'b001, 32'h0}) begin
            bad++;
            $display("FAIL reset_wait_after: q=%b ret=%b rdy=%b wd=%h required 0 0 1 0", wd_q_o, retire_o, ex_ready_o, wd_o);
        end
        settle(2);
        total++;
        if (wr_q.size() != wbase || retire_cnt != rbase) begin
            bad++;
            $display("FAIL reset_wait_count: writes=%0d retires=%0d required %0d %0d", wr_q.size(), retire_cnt, wbase, rbase);
        end
        issue(K_ALU, 5'd9, 32'h1234_5678, 32'h0, 3'd0, 2'd0);
        #1 reset = 1'b0;
        #1;
        total++;
        if (wd_q_o !== 1'b0) begin bad++; $display("FAIL reset_write_strobe: q=%b required 0", wd_q_o); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [36:0] exp_q[$];
        int wbase, rbase, mbase, tbase;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  a;
        logic [31:0] v, w;
        int exp_ret, exp_mis;
        settle(1);
        wbase = wr_q.size(); rbase = retire_cnt; mbase = misalign_cnt; tbase = timeout_cnt;
        exp_ret = 0; exp_mis = 0;
        for (int i = 0; i < 60; i++) begin
            kind = 2'($urandom_range(0, 3));
            rd   = 5'($urandom_range(0, 31));
            f3   = 3'($urandom_range(0, 7));
            a    = 2'($urandom_range(0, 3));
            v    = $urandom;
            w    = $urandom;
            issue(kind, rd, v, w, f3, a);
            exp_ret++;
            if (kind == K_ALU || kind == K_LINK) begin
                if (rd != 0) exp_q.push_back({rd, (kind == K_ALU) ? v : w + 32'd4});
            end else if (kind == K_LOAD) begin
                if (ref_misaligned(f3, a)) begin
                    exp_mis++;
                end else begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    mem_respond(v);
                    if (rd != 0) exp_q.push_back({rd, ref_load(f3, a, v)});
                end
            end
        end
        settle(3);
        total++;
        if (wr_q.size() - wbase != exp_q.size()) begin
            bad++;
            $display("FAIL rand_write_count: writes=%0d required %0d", wr_q.size() - wbase, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && wbase + i < wr_q.size(); i++) begin
            total++;
            if (wr_q[wbase + i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rand_write%0d: rd=%0d wd=%h required rd=%0d wd=%h", i,
                         wr_q[wbase + i][36:32], wr_q[wbase + i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
            end
        end
        total++;
        if (retire_cnt - rbase != exp_ret || misalign_cnt - mbase != exp_mis || timeout_cnt != tbase) begin
            bad++;
            $display("FAIL rand_pulses: ret=%0d mis=%0d to=%0d required %0d %0d 0",
                     retire_cnt - rbase, misalign_cnt - mbase, timeout_cnt - tbase, exp_ret, exp_mis);
        end
        total++;
        if (run_max > 1) begin bad++; $display("FAIL strobe_width: longest=%0d required 1", run_max); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_examples();
        test_misalign();
        test_link();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
